// File: rtl/full_st0_error_tx_pkg.sv
// Shared types and widths for the stage-0 error transmit path.
// Frame-length and phase widths must stay in step with the stage-0 receiver.
package full_st0_error_tx_pkg;

  typedef logic [31:0] float_24_8;

  localparam int FRAME_LEN_W = 4;
  localparam int PHASE_W     = 2;

endpackage

// File: rtl/full_sync_fifo.sv
// Show-ahead synchronous FIFO with flush; the head word is visible while not empty.
// Shared by the stage controllers.
module full_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [DW-1:0] ram [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          push;
  logic          pop;

  assign full  = (level_q == LVL_FULL);
  assign empty = (level_q == '0);
  assign level = level_q;
  assign push  = wr_en & ~full;
  assign pop   = rd_en & ~empty;

  // Mask the head when empty so the output reads zero after reset/flush.
  assign rd_data = empty ? '0 : ram[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (push && !pop)      level_d = level_q + LVL_ONE;
      else if (pop && !push) level_d = level_q - LVL_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) ram[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/full_st0_error_tx.sv
// Stage-0 error transmitter: buffers error words and emits them as framed
// valid/ready bursts with first-word flag, word index and frame phase.
module full_st0_error_tx
  import full_st0_error_tx_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic [FRAME_LEN_W-1:0] frame_length,
  input  float_24_8              err_in,
  input  logic                   err_in_vld,
  output logic                   err_in_rdy,
  output float_24_8              stage_0_error,
  output logic                   stage_0_error_vld,
  output logic                   stage_0_error_fst,
  input  logic                   stage_0_error_rdy,
  output logic [FRAME_LEN_W-1:0] tx_count,
  output logic [PHASE_W-1:0]     tx_phase,
  output logic                   frame_done,
  output logic [AW:0]            fifo_level
);

  localparam logic [FRAME_LEN_W-1:0] CNT_ONE   = FRAME_LEN_W'(1);
  localparam logic [PHASE_W-1:0]     PHASE_ONE = PHASE_W'(1);

  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   push;
  logic                   pop;
  logic [FRAME_LEN_W-1:0] cur_len;
  logic [FRAME_LEN_W-1:0] tx_count_q, tx_count_d;
  logic [FRAME_LEN_W-1:0] len_q, len_d;
  logic [PHASE_W-1:0]     tx_phase_q, tx_phase_d;
  logic                   frame_done_q, frame_done_d;

  assign err_in_rdy        = ~fifo_full;
  assign stage_0_error_vld = ~fifo_empty;
  assign push              = err_in_vld & err_in_rdy;
  assign pop               = stage_0_error_vld & stage_0_error_rdy;
  assign stage_0_error_fst = stage_0_error_vld & (tx_count_q == '0);

  full_sync_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (32)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush),
    .wr_en   (push),
    .wr_data (err_in),
    .rd_en   (pop),
    .rd_data (stage_0_error),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // Word 0 sees the live length; the rest of the frame uses the latched copy.
  assign cur_len = (tx_count_q == '0) ? frame_length : len_q;

  always_comb begin
    tx_count_d   = tx_count_q;
    len_d        = len_q;
    tx_phase_d   = tx_phase_q;
    frame_done_d = 1'b0;
    if (flush) begin
      tx_count_d = '0;
      len_d      = '0;
    end else if (pop) begin
      if (tx_count_q == '0) len_d = frame_length;
      if (tx_count_q == cur_len) begin
        tx_count_d   = '0;
        frame_done_d = 1'b1;
        tx_phase_d   = tx_phase_q + PHASE_ONE;
      end else begin
        tx_count_d = tx_count_q + CNT_ONE;
      end
    end
  end

  // Phase survives flush so it stays aligned with the receiver.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_count_q   <= '0;
      len_q        <= '0;
      tx_phase_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      tx_count_q   <= tx_count_d;
      len_q        <= len_d;
      tx_phase_q   <= tx_phase_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign tx_count   = tx_count_q;
  assign tx_phase   = tx_phase_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_full_st0_error_tx.sv
// Directed self-checking bench for full_st0_error_tx; inputs change and outputs
// are sampled around the falling edge.
module tb_full_st0_error_tx;
  import full_st0_error_tx_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       flush = 1'b0;
  logic [3:0] frame_length = 4'd0;
  float_24_8  err_in = '0;
  logic       err_in_vld = 1'b0;
  logic       err_in_rdy;
  float_24_8  stage_0_error;
  logic       stage_0_error_vld;
  logic       stage_0_error_fst;
  logic       stage_0_error_rdy = 1'b0;
  logic [3:0] tx_count;
  logic [1:0] tx_phase;
  logic       frame_done;
  logic [2:0] fifo_level;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  full_st0_error_tx #(.DEPTH(4), .AW(2)) dut (
    .clk               (clk),
    .reset             (reset),
    .flush             (flush),
    .frame_length      (frame_length),
    .err_in            (err_in),
    .err_in_vld        (err_in_vld),
    .err_in_rdy        (err_in_rdy),
    .stage_0_error     (stage_0_error),
    .stage_0_error_vld (stage_0_error_vld),
    .stage_0_error_fst (stage_0_error_fst),
    .stage_0_error_rdy (stage_0_error_rdy),
    .tx_count          (tx_count),
    .tx_phase          (tx_phase),
    .frame_done        (frame_done),
    .fifo_level        (fifo_level)
  );

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Push one word into an empty FIFO with the receiver ready, then let it pop.
  task automatic send_word(input logic [31:0] w);
    err_in = w; err_in_vld = 1'b1;
    step;
    err_in_vld = 1'b0;
    step;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    step;
    total_cnt++; if (stage_0_error_vld !== 1'b0) $display("FAIL reset_vld_during: got %0b want 0", stage_0_error_vld); else pass_cnt++;
    reset = 1'b0;
    #1;
    total_cnt++; if (err_in_rdy !== 1'b1) $display("FAIL reset_err_in_rdy: got %0b want 1", err_in_rdy); else pass_cnt++;
    total_cnt++; if (stage_0_error !== 32'h0) $display("FAIL reset_data: got %h want 0", stage_0_error); else pass_cnt++;
    total_cnt++; if (stage_0_error_fst !== 1'b0) $display("FAIL reset_fst: got %0b want 0", stage_0_error_fst); else pass_cnt++;
    total_cnt++; if (tx_count !== 4'd0) $display("FAIL reset_tx_count: got %0d want 0", tx_count); else pass_cnt++;
    total_cnt++; if (tx_phase !== 2'd0) $display("FAIL reset_tx_phase: got %0d want 0", tx_phase); else pass_cnt++;
    total_cnt++; if (frame_done !== 1'b0) $display("FAIL reset_frame_done: got %0b want 0", frame_done); else pass_cnt++;
    total_cnt++; if (fifo_level !== 3'd0) $display("FAIL reset_level: got %0d want 0", fifo_level); else pass_cnt++;
    $display("test_reset done");
  endtask

  task automatic test_basic_frame;
    logic [31:0] w;
    frame_length = 4'd3; stage_0_error_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      w = 32'h3F80_0000 + 32'(i);
      err_in = w; err_in_vld = 1'b1;
      step;
      total_cnt++; if (stage_0_error !== w) $display("FAIL basic_data%0d: got %h want %h", i, stage_0_error, w); else pass_cnt++;
      total_cnt++; if (stage_0_error_fst !== (i == 0)) $display("FAIL basic_fst%0d: got %0b want %0b", i, stage_0_error_fst, (i == 0)); else pass_cnt++;
      total_cnt++; if (tx_count !== 4'(i)) $display("FAIL basic_count%0d: got %0d want %0d", i, tx_count, i); else pass_cnt++;
      total_cnt++; if (frame_done !== 1'b0) $display("FAIL basic_done_early%0d: got %0b want 0", i, frame_done); else pass_cnt++;
      $display("basic word %0d out %h", i, stage_0_error);
    end
    err_in_vld = 1'b0;
    step;
    total_cnt++; if (frame_done !== 1'b1) $display("FAIL basic_frame_done: got %0b want 1", frame_done); else pass_cnt++;
    total_cnt++; if (tx_phase !== 2'd1) $display("FAIL basic_phase: got %0d want 1", tx_phase); else pass_cnt++;
    total_cnt++; if (tx_count !== 4'd0) $display("FAIL basic_count_wrap: got %0d want 0", tx_count); else pass_cnt++;
    total_cnt++; if (stage_0_error_vld !== 1'b0) $display("FAIL basic_vld_empty: got %0b want 0", stage_0_error_vld); else pass_cnt++;
    step;
    total_cnt++; if (frame_done !== 1'b0) $display("FAIL basic_done_pulse: got %0b want 0", frame_done); else pass_cnt++;
  endtask

  task automatic test_backpressure;
    logic [31:0] w;
    logic push_now;
    int got;
    frame_length = 4'd3; stage_0_error_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      err_in = 32'hBF00_0000 + 32'(i); err_in_vld = 1'b1;
      total_cnt++; if (err_in_rdy !== 1'b1) $display("FAIL bp_rdy%0d: got %0b want 1", i, err_in_rdy); else pass_cnt++;
      step;
    end
    total_cnt++; if (fifo_level !== 3'd4) $display("FAIL bp_level_full: got %0d want 4", fifo_level); else pass_cnt++;
    total_cnt++; if (err_in_rdy !== 1'b0) $display("FAIL bp_rdy_full: got %0b want 0", err_in_rdy); else pass_cnt++;
    err_in = 32'hBF00_0004; err_in_vld = 1'b1;
    step;
    total_cnt++; if (fifo_level !== 3'd4) $display("FAIL bp_level_held: got %0d want 4", fifo_level); else pass_cnt++;
    total_cnt++; if (stage_0_error !== 32'hBF00_0000) $display("FAIL bp_head_held: got %h want bf000000", stage_0_error); else pass_cnt++;
    stage_0_error_rdy = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && got < 5; c++) begin
      if (stage_0_error_vld) begin
        w = 32'hBF00_0000 + 32'(got);
        total_cnt++; if (stage_0_error !== w) $display("FAIL bp_order%0d: got %h want %h", got, stage_0_error, w); else pass_cnt++;
        $display("bp word %0d out %h", got, stage_0_error);
        got++;
      end
      push_now = err_in_vld & err_in_rdy;
      step;
      if (push_now) err_in_vld = 1'b0;
    end
    stage_0_error_rdy = 1'b0;
    total_cnt++; if (got !== 5) $display("FAIL bp_word_count: got %0d want 5", got); else pass_cnt++;
    total_cnt++; if (fifo_level !== 3'd0) $display("FAIL bp_level_drained: got %0d want 0", fifo_level); else pass_cnt++;
    total_cnt++; if (tx_count !== 4'd1) $display("FAIL bp_count: got %0d want 1", tx_count); else pass_cnt++;
    total_cnt++; if (tx_phase !== 2'd2) $display("FAIL bp_phase: got %0d want 2", tx_phase); else pass_cnt++;
  endtask

  task automatic test_flush;
    stage_0_error_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      err_in = 32'hC000_0000 + 32'(i); err_in_vld = 1'b1;
      step;
    end
    err_in_vld = 1'b0;
    stage_0_error_rdy = 1'b1;
    step;
    stage_0_error_rdy = 1'b0;
    total_cnt++; if (tx_count !== 4'd2) $display("FAIL flush_pre_count: got %0d want 2", tx_count); else pass_cnt++;
    total_cnt++; if (fifo_level !== 3'd2) $display("FAIL flush_pre_level: got %0d want 2", fifo_level); else pass_cnt++;
    flush = 1'b1; err_in = 32'hC0FF_EE00; err_in_vld = 1'b1;
    step;
    flush = 1'b0; err_in_vld = 1'b0;
    total_cnt++; if (fifo_level !== 3'd0) $display("FAIL flush_level: got %0d want 0", fifo_level); else pass_cnt++;
    total_cnt++; if (stage_0_error_vld !== 1'b0) $display("FAIL flush_vld: got %0b want 0", stage_0_error_vld); else pass_cnt++;
    total_cnt++; if (tx_count !== 4'd0) $display("FAIL flush_count: got %0d want 0", tx_count); else pass_cnt++;
    total_cnt++; if (tx_phase !== 2'd2) $display("FAIL flush_phase_kept: got %0d want 2", tx_phase); else pass_cnt++;
    total_cnt++; if (stage_0_error !== 32'h0) $display("FAIL flush_data: got %h want 0", stage_0_error); else pass_cnt++;
    total_cnt++; if (err_in_rdy !== 1'b1) $display("FAIL flush_rdy: got %0b want 1", err_in_rdy); else pass_cnt++;
    $display("test_flush done");
  endtask

  task automatic test_reset_mid;
    frame_length = 4'd3; stage_0_error_rdy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      err_in = 32'hD000_0000 + 32'(i); err_in_vld = 1'b1;
      step;
    end
    err_in_vld = 1'b0;
    stage_0_error_rdy = 1'b1;
    step;
    stage_0_error_rdy = 1'b0;
    total_cnt++; if (stage_0_error !== 32'hD000_0001) $display("FAIL rmid_head: got %h want d0000001", stage_0_error); else pass_cnt++;
    #2 reset = 1'b1;
    #1;
    total_cnt++; if (stage_0_error_vld !== 1'b0) $display("FAIL rmid_vld: got %0b want 0", stage_0_error_vld); else pass_cnt++;
    total_cnt++; if (fifo_level !== 3'd0) $display("FAIL rmid_level: got %0d want 0", fifo_level); else pass_cnt++;
    total_cnt++; if (stage_0_error !== 32'h0) $display("FAIL rmid_data: got %h want 0", stage_0_error); else pass_cnt++;
    total_cnt++; if (tx_count !== 4'd0) $display("FAIL rmid_count: got %0d want 0", tx_count); else pass_cnt++;
    total_cnt++; if (tx_phase !== 2'd0) $display("FAIL rmid_phase: got %0d want 0", tx_phase); else pass_cnt++;
    @(negedge clk);
    reset = 1'b0;
    $display("test_reset_mid done");
  endtask

  task automatic test_single_word;
    logic [31:0] w;
    frame_length = 4'd0; stage_0_error_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      w = 32'hE000_0000 + 32'(i);
      err_in = w; err_in_vld = 1'b1;
      step;
      total_cnt++; if (stage_0_error !== w) $display("FAIL sw_data%0d: got %h want %h", i, stage_0_error, w); else pass_cnt++;
      total_cnt++; if (stage_0_error_fst !== 1'b1) $display("FAIL sw_fst%0d: got %0b want 1", i, stage_0_error_fst); else pass_cnt++;
      if (i > 0) begin
        total_cnt++; if (frame_done !== 1'b1) $display("FAIL sw_done%0d: got %0b want 1", i, frame_done); else pass_cnt++;
        total_cnt++; if (tx_phase !== 2'(i)) $display("FAIL sw_phase%0d: got %0d want %0d", i, tx_phase, i % 4); else pass_cnt++;
      end
    end
    err_in_vld = 1'b0;
    step;
    total_cnt++; if (frame_done !== 1'b1) $display("FAIL sw_done_last: got %0b want 1", frame_done); else pass_cnt++;
    total_cnt++; if (tx_phase !== 2'd1) $display("FAIL sw_phase_last: got %0d want 1", tx_phase); else pass_cnt++;
    total_cnt++; if (fifo_level !== 3'd0) $display("FAIL sw_level: got %0d want 0", fifo_level); else pass_cnt++;
  endtask

  task automatic test_len_change;
    logic [3:0] exp_cnt;
    stage_0_error_rdy = 1'b1;
    frame_length = 4'd2;
    send_word(32'hA000_0000);
    total_cnt++; if (tx_count !== 4'd1) $display("FAIL lc_count0: got %0d want 1", tx_count); else pass_cnt++;
    frame_length = 4'd5;
    send_word(32'hA000_0001);
    total_cnt++; if (frame_done !== 1'b0 || tx_count !== 4'd2) $display("FAIL lc_word1: got done=%0b cnt=%0d want done=0 cnt=2", frame_done, tx_count); else pass_cnt++;
    send_word(32'hA000_0002);
    total_cnt++; if (frame_done !== 1'b1 || tx_count !== 4'd0) $display("FAIL lc_word2: got done=%0b cnt=%0d want done=1 cnt=0", frame_done, tx_count); else pass_cnt++;
    for (int k = 1; k <= 6; k++) begin
      send_word(32'hA100_0000 + 32'(k));
      if (k == 1) frame_length = 4'd1;
      exp_cnt = (k == 6) ? 4'd0 : 4'(k);
      total_cnt++; if (frame_done !== (k == 6) || tx_count !== exp_cnt) $display("FAIL lc_f2_word%0d: got done=%0b cnt=%0d want done=%0b cnt=%0d", k, frame_done, tx_count, (k == 6), exp_cnt); else pass_cnt++;
    end
    total_cnt++; if (tx_phase !== 2'd3) $display("FAIL lc_phase: got %0d want 3", tx_phase); else pass_cnt++;
    $display("test_len_change done");
  endtask

  task automatic test_full_simul;
    logic [31:0] w;
    int got;
    frame_length = 4'd3; stage_0_error_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      err_in = 32'hF000_0000 + 32'(i); err_in_vld = 1'b1;
      step;
    end
    total_cnt++; if (fifo_level !== 3'd4 || err_in_rdy !== 1'b0) $display("FAIL fs_full: got lvl=%0d rdy=%0b want lvl=4 rdy=0", fifo_level, err_in_rdy); else pass_cnt++;
    err_in = 32'hF000_0004; err_in_vld = 1'b1; stage_0_error_rdy = 1'b1;
    step;
    total_cnt++; if (fifo_level !== 3'd3) $display("FAIL fs_level_pop: got %0d want 3", fifo_level); else pass_cnt++;
    total_cnt++; if (err_in_rdy !== 1'b1) $display("FAIL fs_rdy_back: got %0b want 1", err_in_rdy); else pass_cnt++;
    total_cnt++; if (stage_0_error !== 32'hF000_0001) $display("FAIL fs_head1: got %h want f0000001", stage_0_error); else pass_cnt++;
    step;
    err_in_vld = 1'b0;
    total_cnt++; if (fifo_level !== 3'd3) $display("FAIL fs_level_both: got %0d want 3", fifo_level); else pass_cnt++;
    got = 2;
    for (int c = 0; c < 10 && got < 5; c++) begin
      if (stage_0_error_vld) begin
        w = 32'hF000_0000 + 32'(got);
        total_cnt++; if (stage_0_error !== w) $display("FAIL fs_order%0d: got %h want %h", got, stage_0_error, w); else pass_cnt++;
        $display("fs word %0d out %h", got, stage_0_error);
        got++;
      end
      step;
    end
    total_cnt++; if (got !== 5 || fifo_level !== 3'd0) $display("FAIL fs_drain: got words=%0d lvl=%0d want words=5 lvl=0", got, fifo_level); else pass_cnt++;
    stage_0_error_rdy = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(negedge clk);
    test_reset;
    test_basic_frame;
    test_backpressure;
    test_flush;
    test_reset_mid;
    test_single_word;
    test_len_change;
    test_full_simul;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
